oled_spi_ctrl: RTL and testbench

- Hardware SPI master for the PMOD SSD1331 OLED. It replaces CPU bit-banging of the 8-bit OLED IO register.
- The CPU IO write path pushes {dc, byte} entries into a small FIFO. The block runs the panel power-up sequence, then shifts queued bytes out MSB-first in SPI mode 0.
- It sits on the IO decode next to the LED and 7-segment registers. Its outputs drive the OLED_* pins directly.

---
 rtl/oled_spi_ctrl.sv | 139 +++++++++++++
 tb/tb_oled_spi_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_ctrl.sv
// oled_spi_ctrl: SSD1331 PMOD OLED power-up sequencer and FIFO-fed SPI mode-0 master.
// Every pin output is a flop, so the panel never sees combinational glitches.
module oled_spi_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int PWR_CYCLES = 16,
    parameter int RES_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       ready,
    output logic       overflow,
    output logic       oled_cs,
    output logic       oled_mosi,
    output logic       oled_sck,
    output logic       oled_dc,
    output logic       oled_res,
    output logic       oled_vcc_en,
    output logic       oled_pmod_en
);
    localparam int MAXA = CLK_DIV > PWR_CYCLES ? CLK_DIV : PWR_CYCLES;
    localparam int MAXC = MAXA > RES_CYCLES ? MAXA : RES_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PWR_END = CW'(PWR_CYCLES - 1);
    localparam logic [CW-1:0] RES_END = CW'(RES_CYCLES - 1);

    typedef enum logic [2:0] {PWR_ON, RES_LOW, RES_HIGH, IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    sr_q, sr_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    head;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [NW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, ready_q, ready_d, cs_q, cs_d, mosi_q, mosi_d;
    logic          sck_q, sck_d, dc_q, dc_d, res_q, res_d, pmod_q, pmod_d;
    logic          empty, push, pop, tick, rise, fall;

    assign empty = count_q == '0;
    assign full  = count_q == NW'(FIFO_DEPTH);
    assign push  = wr_en && !full;
    assign pop   = state_d == LOAD;
    assign head  = mem_q[rp_q];
    assign tick  = cnt_q == DIV_END;
    assign rise  = state_q == SHIFT && tick && !sck_q;
    assign fall  = state_q == SHIFT && tick && sck_q;
    assign wp_d  = push ? wp_q + AW'(1) : wp_q;
    assign rp_d  = pop ? rp_q + AW'(1) : rp_q;
    assign count_d = count_q + NW'(push) - NW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PWR_ON;
            cnt_q      <= '0;
            bit_q      <= '0;
            sr_q       <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            sck_q      <= 1'b0;
            dc_q       <= 1'b0;
            res_q      <= 1'b1;
            pmod_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ready_q    <= ready_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            sck_q      <= sck_d;
            dc_q       <= dc_d;
            res_q      <= res_d;
            pmod_q     <= pmod_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wr_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PWR_ON:   if (cnt_q == PWR_END) state_d = RES_LOW;
            RES_LOW:  if (cnt_q == RES_END) state_d = RES_HIGH;
            RES_HIGH: if (cnt_q == RES_END) state_d = IDLE;
            IDLE:     if (!empty) state_d = LOAD;
            LOAD:     state_d = SHIFT;
            SHIFT:    if (fall && bit_q == '0) state_d = empty ? DONE : LOAD;
            DONE:     if (tick) state_d = IDLE;
            default:  state_d = PWR_ON;
        endcase
        // one counter serves init waits, the SCK divider and the DONE hold
        cnt_d = (state_q == IDLE || state_d != state_q || (state_q == SHIFT && tick)) ? '0 : cnt_q + CW'(1);
        bit_d = state_q == LOAD ? 3'd7 : fall ? bit_q - 3'd1 : bit_q;
    end

    always_comb begin
        pmod_d     = 1'b1;
        res_d      = state_d != RES_LOW;
        ready_d    = state_d inside {IDLE, LOAD, SHIFT, DONE};
        cs_d       = !(state_d inside {LOAD, SHIFT, DONE});
        sck_d      = rise ? 1'b1 : fall ? 1'b0 : sck_q;
        mosi_d     = pop ? head[7] : (fall && bit_q != '0) ? sr_q[6] : cs_d ? 1'b0 : mosi_q;
        sr_d       = pop ? head[6:0] : fall ? {sr_q[5:0], 1'b0} : sr_q;
        dc_d       = pop ? head[8] : dc_q;
        overflow_d = overflow_q || (wr_en && full);
    end

    assign busy         = !ready_q || state_q != IDLE || !empty;
    assign ready        = ready_q;
    assign overflow     = overflow_q;
    assign oled_cs      = cs_q;
    assign oled_mosi    = mosi_q;
    assign oled_sck     = sck_q;
    assign oled_dc      = dc_q;
    assign oled_res     = res_q;
    assign oled_vcc_en  = ready_q;
    assign oled_pmod_en = pmod_q;
endmodule

// File: tb/tb_oled_spi_ctrl.sv
// tb_oled_spi_ctrl: decodes the SPI pins back into {dc, byte} entries and compares
// them with the entries the bench pushed, plus init timing and SCK shape.
module tb_oled_spi_ctrl;
    logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
    logic [8:0] wr_data = '0;
    logic       full, busy, ready, overflow, oled_cs, oled_mosi, oled_sck, oled_dc;
    logic       oled_res, oled_vcc_en, oled_pmod_en;
    int         checks = 0, failures = 0;
    logic [8:0] rx[$];
    int         nbit = 0, lo = 0, hi = 0, cslen = 0, last_cs_low = 0, cs_rises = 0, sck_rises = 0;
    logic       p_cs = 1'b1, p_sck = 1'b0, rmosi = 1'b0, bdc = 1'b0;
    logic [7:0] sh = '0;

    oled_spi_ctrl dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .busy(busy),
        .ready(ready), .overflow(overflow), .oled_cs(oled_cs), .oled_mosi(oled_mosi),
        .oled_sck(oled_sck), .oled_dc(oled_dc), .oled_res(oled_res), .oled_vcc_en(oled_vcc_en),
        .oled_pmod_en(oled_pmod_en)
    );

    always #5 clk = ~clk;

    // SPI receiver: low phase is 2 cycles, or 3 before a byte's first bit (LOAD + 2)
    always @(negedge clk) begin
        if (reset) begin
            nbit = 0; p_cs = 1'b1; p_sck = 1'b0;
        end else begin
            if (!oled_cs && p_cs) begin
                lo = 1; cslen = 1; nbit = 0;
            end else if (!oled_cs) begin
                cslen++;
                if (oled_sck && !p_sck) begin
                    checks++;
                    if (lo != (nbit == 0 ? 3 : 2)) begin
                        failures++; $display("FAIL sck_low_len got=%0d want=%0d", lo, nbit == 0 ? 3 : 2);
                    end
                    if (nbit == 0) bdc = oled_dc;
                    else begin
                        checks++;
                        if (oled_dc !== bdc) begin failures++; $display("FAIL dc_stable got=%b want=%b", oled_dc, bdc); end
                    end
                    rmosi = oled_mosi; sh = {sh[6:0], oled_mosi}; hi = 1; nbit++; sck_rises++;
                    if (nbit == 8) begin rx.push_back({bdc, sh}); nbit = 0; end
                end else if (oled_sck) begin
                    hi++; checks++;
                    if (oled_mosi !== rmosi) begin failures++; $display("FAIL mosi_stable got=%b want=%b", oled_mosi, rmosi); end
                end else if (p_sck) begin
                    checks++;
                    if (hi != 2) begin failures++; $display("FAIL sck_high_len got=%0d want=2", hi); end
                    lo = 1;
                end else lo++;
            end else if (!p_cs) begin
                last_cs_low = cslen; cs_rises++;
            end
            p_cs = oled_cs; p_sck = oled_sck;
        end
    end

    task automatic push(input logic [8:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_init(output bit ok);
        reset = 1'b1; wr_en = 1'b0; ok = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin ok = 1; break; end
        end
        #1 rx.delete();
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        #1;
    endtask

    task automatic wait_cs_high(output bit ok);
        bit seen = 0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!oled_cs) seen = 1;
            else if (seen) begin ok = 1; break; end
        end
        #1;
    endtask

    task automatic test_reset;
        int t_pmod = -1, t_lo = -1, t_hi = -1, t_rdy = -1, t_vcc = -1;
        bit cs_ok = 1;
        reset = 1'b1; wr_en = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({oled_cs, oled_mosi, oled_sck, oled_dc, oled_res, oled_vcc_en, oled_pmod_en} !== 7'b1000100) begin
            failures++; $display("FAIL reset_pins got=%b want=1000100",
                {oled_cs, oled_mosi, oled_sck, oled_dc, oled_res, oled_vcc_en, oled_pmod_en});
        end
        checks++;
        if ({ready, overflow, busy, full} !== 4'b0010) begin
            failures++; $display("FAIL reset_status got=%b want=0010", {ready, overflow, busy, full});
        end
        @(negedge clk); reset = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (oled_pmod_en && t_pmod < 0) t_pmod = k;
            if (!oled_res && t_lo < 0) t_lo = k;
            if (oled_res && t_lo >= 0 && t_hi < 0) t_hi = k;
            if (ready && t_rdy < 0) t_rdy = k;
            if (oled_vcc_en && t_vcc < 0) t_vcc = k;
            if (!oled_cs) cs_ok = 0;
        end
        checks++; if (t_pmod != 1) begin failures++; $display("FAIL pmod_en_cycle got=%0d want=1", t_pmod); end
        checks++; if (t_lo != 16) begin failures++; $display("FAIL res_low_cycle got=%0d want=16", t_lo); end
        checks++; if (t_hi != 32) begin failures++; $display("FAIL res_high_cycle got=%0d want=32", t_hi); end
        checks++; if (t_rdy != 48) begin failures++; $display("FAIL ready_cycle got=%0d want=48", t_rdy); end
        checks++; if (t_vcc != 48) begin failures++; $display("FAIL vcc_en_cycle got=%0d want=48", t_vcc); end
        checks++; if (!cs_ok) begin failures++; $display("FAIL init_cs got=0 want=1"); end
        #1;
    endtask

    task automatic test_single;
        int c0 = cs_rises, s0 = sck_rises;
        bit ok;
        rx.delete();
        push(9'h1A5);
        wait_cs_high(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=0 want=1"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b want=0", busy); end
        checks++;
        if ({oled_mosi, oled_sck} !== 2'b00) begin
            failures++; $display("FAIL single_idle_pins got=%b want=00", {oled_mosi, oled_sck});
        end
        checks++;
        if (rx.size() != 1 || rx[0] !== 9'h1A5) begin
            failures++; $display("FAIL single_byte got=%0d/%h want=1/1a5", rx.size(), rx.size() > 0 ? rx[0] : 9'h0);
        end
        checks++; if (sck_rises - s0 != 8) begin failures++; $display("FAIL single_pulses got=%0d want=8", sck_rises - s0); end
        checks++; if (cs_rises - c0 != 1) begin failures++; $display("FAIL single_cs_rises got=%0d want=1", cs_rises - c0); end
        checks++; if (last_cs_low != 35) begin failures++; $display("FAIL single_cs_low got=%0d want=35", last_cs_low); end
    endtask

    task automatic test_back_to_back;
        int c0 = cs_rises, s0 = sck_rises;
        bit ok;
        rx.delete();
        push(9'h0AE);
        push(9'h1FF);
        wait_cs_high(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=0 want=1"); end
        checks++; if (cs_rises - c0 != 1) begin failures++; $display("FAIL b2b_cs_rises got=%0d want=1", cs_rises - c0); end
        checks++; if (sck_rises - s0 != 16) begin failures++; $display("FAIL b2b_pulses got=%0d want=16", sck_rises - s0); end
        checks++; if (last_cs_low != 68) begin failures++; $display("FAIL b2b_cs_low got=%0d want=68", last_cs_low); end
        checks++;
        if (rx.size() != 2 || rx[0] !== 9'h0AE || rx[1] !== 9'h1FF) begin
            failures++; $display("FAIL b2b_bytes got=%0d entries want=0ae,1ff", rx.size());
        end
    endtask

    task automatic test_random;
        logic [8:0] exp_q[$];
        logic [8:0] d, got;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 4);
            rx.delete(); exp_q.delete();
            for (int i = 0; i < n; i++) begin
                d = 9'($urandom);
                exp_q.push_back(d);
                push(d);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(600, ok);
            checks++; if (!ok) begin failures++; $display("FAIL random_timeout got=0 want=1"); end
            checks++; if (rx.size() != n) begin failures++; $display("FAIL random_count got=%0d want=%0d", rx.size(), n); end
            for (int i = 0; i < n; i++) begin
                got = i < rx.size() ? rx[i] : 9'h0;
                checks++;
                if (got !== exp_q[i]) begin failures++; $display("FAIL random_entry%0d got=%h want=%h", i, got, exp_q[i]); end
            end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL random_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_push_pop;
        logic [8:0] d [6];
        logic [8:0] got;
        bit ok;
        for (int i = 0; i < 6; i++) d[i] = 9'($urandom);
        do_init(ok);
        checks++; if (!ok) begin failures++; $display("FAIL pp_init got=0 want=1"); end
        wr_en = 1'b1; wr_data = d[0];
        @(negedge clk);
        wr_data = d[1];
        @(negedge clk);
        checks++; if (oled_cs !== 1'b0) begin failures++; $display("FAIL pp_cs_fall got=%b want=0", oled_cs); end
        wr_data = d[2];
        @(negedge clk);
        wr_data = d[3];
        @(negedge clk);
        wr_en = 1'b0;
        for (int j = 3; j <= 32; j++) @(negedge clk);
        // this push lands on the edge that pops byte 2
        wr_en = 1'b1; wr_data = d[4];
        @(negedge clk);
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL pp_count3 got_full=%b want=0", full); end
        wr_data = d[5];
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL pp_count4 got_full=%b want=1", full); end
        wait_idle(600, ok);
        checks++; if (!ok) begin failures++; $display("FAIL pp_timeout got=0 want=1"); end
        checks++; if (rx.size() != 6) begin failures++; $display("FAIL pp_count got=%0d want=6", rx.size()); end
        for (int i = 0; i < 6; i++) begin
            got = i < rx.size() ? rx[i] : 9'h0;
            checks++;
            if (got !== d[i]) begin failures++; $display("FAIL pp_entry%0d got=%h want=%h", i, got, d[i]); end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_overflow;
        logic [8:0] d [5];
        logic [8:0] got;
        bit ok;
        for (int i = 0; i < 5; i++) d[i] = 9'($urandom);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 rx.delete();
        for (int i = 0; i < 4; i++) push(d[i]);
        checks++;
        if ({full, overflow} !== 2'b10) begin
            failures++; $display("FAIL ovf_full4 got=%b want=10", {full, overflow});
        end
        push(d[4]);
        checks++;
        if ({full, overflow, oled_cs} !== 3'b111) begin
            failures++; $display("FAIL ovf_drop got=%b want=111", {full, overflow, oled_cs});
        end
        wait_idle(1000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got=0 want=1"); end
        checks++; if (rx.size() != 4) begin failures++; $display("FAIL ovf_count got=%0d want=4", rx.size()); end
        for (int i = 0; i < 4; i++) begin
            got = i < rx.size() ? rx[i] : 9'h0;
            checks++;
            if (got !== d[i]) begin failures++; $display("FAIL ovf_entry%0d got=%h want=%h", i, got, d[i]); end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_reset_mid;
        int n = 0, t_rdy = -1;
        bit ok, ps = 0, cs_ok = 1;
        do_init(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_init got=0 want=1"); end
        push(9'($urandom));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (oled_sck && !ps) n++;
            ps = oled_sck;
            if (n == 4) break;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL mid_4th_high got=%0d want=4", n); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({oled_cs, oled_sck, oled_res, oled_pmod_en, ready, busy} !== 6'b101001) begin
            failures++; $display("FAIL mid_async got=%b want=101001",
                {oled_cs, oled_sck, oled_res, oled_pmod_en, ready, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (ready && t_rdy < 0) t_rdy = k;
            if (!oled_cs) cs_ok = 0;
        end
        #1;
        checks++; if (t_rdy != 48) begin failures++; $display("FAIL mid_ready_cycle got=%0d want=48", t_rdy); end
        checks++; if (!cs_ok) begin failures++; $display("FAIL mid_flushed_cs got=0 want=1"); end
        checks++; if (rx.size() != 0) begin failures++; $display("FAIL mid_flushed_rx got=%0d want=0", rx.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_push_pop();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
